// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding and counter sizing for chunk_serial_addsub
package addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational CHUNK-bit ripple-carry adder exposing the carry into its MSB
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic             ci,
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             c_msb
);
  always_comb begin
    logic [CHUNK:0] c;
    c = '0;
    c[0] = ci;
    sum = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i] = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    co = c[CHUNK];
    c_msb = c[CHUNK-1];
  end
endmodule

// File: rtl/chunk_serial_addsub.sv
// chunk_serial_addsub: multi-cycle add/sub summing CHUNK bits per clock with start/busy/done handshake
module chunk_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = cnt_w(NCHUNK);
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_s, w_res;
  logic [KW-1:0] r_k;
  logic r_c, r_cout, r_ovf, w_co, w_cmsb, w_last;
  logic [CHUNK-1:0] w_sum;
  assign w_last = r_k == KW'(NCHUNK - 1);
  assign s = r_s;
  assign cout = r_cout;
  assign ovf = r_ovf;
  chunk_adder #(.CHUNK(CHUNK)) u_add (
    .ci   (r_c),
    .x    (r_a[r_k*CHUNK +: CHUNK]),
    .y    (r_b[r_k*CHUNK +: CHUNK]),
    .sum  (w_sum),
    .co   (w_co),
    .c_msb(w_cmsb)
  );
  always_comb begin
    w_res = r_acc;
    w_res[r_k*CHUNK +: CHUNK] = w_sum;
  end
  always_comb begin
    busy = r_state == RUN;
    done = r_state == DONE;
    w_next = (r_state == IDLE && start) ? RUN :
             (r_state == RUN && w_last) ? DONE :
             (r_state == DONE) ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // subtraction runs as a + ~b + ~cin, so inversion happens once at capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_acc <= '0;
      r_c <= 1'b0;
      r_k <= '0;
      r_s <= '0;
      r_cout <= 1'b0;
      r_ovf <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_a <= a;
      r_b <= sub ? ~b : b;
      r_c <= sub ^ cin;
      r_k <= '0;
      r_acc <= '0;
    end else if (r_state == RUN) begin
      r_acc <= w_res;
      r_c <= w_co;
      r_k <= r_k + 1'b1;
      if (w_last) begin
        r_s <= w_res;
        r_cout <= w_co;
        r_ovf <= w_co ^ w_cmsb;
      end
    end
  end
endmodule

// File: tb/tb_chunk_serial_addsub.sv
// tb_chunk_serial_addsub: directed and random checks of the serial add/sub against an arithmetic model
module tb_chunk_serial_addsub;
  logic clk = 0, rst = 1, start = 0, sub = 0, cin = 0;
  logic [15:0] a = 0, b = 0, s;
  logic busy, done, cout, ovf;
  logic start8 = 0, sub8 = 0, cin8 = 0;
  logic [7:0] a8 = 0, b8 = 0, s8;
  logic busy8, done8, cout8, ovf8;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  chunk_serial_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf)
  );
  chunk_serial_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .cin(cin8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
  );

  // returns {ovf, cout, s[15:0]} from integer arithmetic on w-bit operands
  function automatic logic [17:0] model(input int w, input logic op, input logic ci,
                                        input logic [15:0] x, input logic [15:0] y);
    longint m, h, ux, uy, r, sx, sy, sr;
    logic [15:0] rs;
    m = longint'(1) << w;
    h = m / 2;
    ux = longint'(x);
    uy = longint'(y);
    r = op ? ux - uy - longint'(ci) : ux + uy + longint'(ci);
    sx = (ux >= h) ? ux - m : ux;
    sy = (uy >= h) ? uy - m : uy;
    sr = op ? sx - sy - longint'(ci) : sx + sy + longint'(ci);
    rs = 16'(r & (m - 1));
    return {(sr >= h) || (sr < -h), op ? (r >= 0) : (r >= m), rs};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input bit scramble, input bit keep, output int n, output int nb);
    n = 0;
    nb = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) nb++;
      if (!keep) start = 0;
      if (scramble && busy) begin
        a = 16'($urandom);
        b = 16'($urandom);
        sub = 1'($urandom);
        cin = 1'($urandom);
      end
    end while (!done && n < 30);
  endtask

  task automatic do_op(input string tag, input logic op, input logic ci,
                       input logic [15:0] x, input logic [15:0] y);
    logic [17:0] e;
    int n, nb;
    e = model(16, op, ci, x, y);
    a = x;
    b = y;
    sub = op;
    cin = ci;
    start = 1;
    wait_done(1'b0, 1'b0, n, nb);
    chk({tag, " latency"}, n, 5);
    chk({tag, " busy_cycles"}, nb, 4);
    chk({tag, " s"}, s, e[15:0]);
    chk({tag, " cout"}, cout, e[16]);
    chk({tag, " ovf"}, ovf, e[17]);
    @(negedge clk);
    chk({tag, " done_pulse"}, done, 0);
  endtask

  initial begin
    logic [17:0] e1, e2;
    int n, nb, cnt;
    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst s", s, 0);
    chk("rst cout", cout, 0);
    chk("rst ovf", ovf, 0);
    chk("rst s8", {busy8, done8, s8, cout8, ovf8}, 0);
    rst = 0;
    @(negedge clk);
    do_op("add1", 0, 0, 16'h1234, 16'h0F0F);
    chk("add1 const", s, 16'h2143);
    do_op("add_wrap", 0, 0, 16'hFFFF, 16'h0001);
    chk("add_wrap const", {cout, ovf, s}, {2'b10, 16'h0000});
    do_op("add_ovf", 0, 1, 16'h7FFF, 16'h0000);
    chk("add_ovf const", {cout, ovf, s}, {2'b01, 16'h8000});
    do_op("sub_neg", 1, 0, 16'h0005, 16'h0007);
    chk("sub_neg const", {cout, ovf, s}, {2'b00, 16'hFFFE});
    do_op("sub_ovf", 1, 0, 16'h8000, 16'h0001);
    chk("sub_ovf const", {cout, ovf, s}, {2'b11, 16'h7FFF});
    do_op("sub_bin", 1, 1, 16'h0000, 16'h0000);
    // start held high, operands scrambled while running
    e1 = model(16, 0, 0, 16'h1111, 16'h2222);
    e2 = model(16, 1, 1, 16'h0100, 16'h0033);
    a = 16'h1111; b = 16'h2222; sub = 0; cin = 0; start = 1;
    wait_done(1'b1, 1'b1, n, nb);
    chk("hold1 latency", n, 5);
    chk("hold1 result", {e1[17:16], s}, {ovf, cout, e1[15:0]});
    a = 16'h0100; b = 16'h0033; sub = 1; cin = 1;
    wait_done(1'b1, 1'b1, n, nb);
    chk("hold2 gap", n, 6);
    chk("hold2 busy_cycles", nb, 4);
    chk("hold2 result", {ovf, cout, s}, e2);
    start = 0;
    @(negedge clk);
    chk("hold2 done_pulse", done, 0);
    for (int i = 0; i < 12; i++)
      do_op($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
    // abort mid-operation after a result with ovf set
    do_op("pre_rst", 0, 1, 16'h7FFF, 16'h0000);
    a = 16'h4321; b = 16'h1111; sub = 0; cin = 0; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort s", s, 0);
    chk("abort flags", {cout, ovf}, 0);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("abort no_done", cnt, 0);
    do_op("post_rst", 1, 0, 16'h4000, 16'h0FFF);
    // single-chunk configuration
    for (int i = 0; i < 5; i++) begin
      logic [7:0] x8, y8;
      logic o8, c8;
      x8 = (i == 0) ? 8'h80 : 8'($urandom);
      y8 = (i == 0) ? 8'h80 : 8'($urandom);
      o8 = (i == 0) ? 1'b0 : 1'($urandom);
      c8 = (i == 0) ? 1'b0 : 1'($urandom);
      e1 = model(8, o8, c8, {8'h00, x8}, {8'h00, y8});
      a8 = x8; b8 = y8; sub8 = o8; cin8 = c8; start8 = 1;
      @(negedge clk);
      start8 = 0;
      chk($sformatf("w8_%0d run", i), {busy8, done8}, 2'b10);
      @(negedge clk);
      chk($sformatf("w8_%0d done", i), {busy8, done8}, 2'b01);
      chk($sformatf("w8_%0d result", i), {ovf8, cout8, s8}, {e1[17:16], e1[7:0]});
      if (i == 0) chk("w8 const", {ovf8, cout8, s8}, {2'b11, 8'h00});
      @(negedge clk);
      chk($sformatf("w8_%0d done_pulse", i), done8, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
